// File: rtl/multi_config_initializer_pkg.sv
// Shared types and constants for the multi-channel configuration loader.
// Bus encodings, word tags and the per-channel word layout live here.
package init_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    localparam int unsigned TAG_WIDTH  = 1;
    localparam int unsigned TAG_HEIGHT = 2;
    localparam int unsigned TAG_RDADDR = 3;
    localparam int unsigned TAG_WRADDR = 4;
    localparam int unsigned TAG_FILTER = 5;

    localparam int unsigned WORDS_PER_CH = 5;

    // Byte offset of word wd of channel ch from the configuration base.
    function automatic int unsigned word_offset(int unsigned ch, int unsigned wd);
        return 4 * (WORDS_PER_CH * ch + wd);
    endfunction

endpackage

// File: rtl/multi_config_initializer_word_checker.sv
// Combinational check of one fetched configuration word: OKAY response and
// matching tag in the top TAG_W bits; the remaining bits are the payload.
module init_word_checker
    import init_pkg::*;
#(
    parameter int BUSWIDTH = 32,
    parameter int TAG_W    = 3
) (
    input  logic [BUSWIDTH-1:0]       hrdata,
    input  logic [1:0]                hresp,
    input  logic [TAG_W-1:0]          exp_tag,
    output logic                      ok,
    output logic [BUSWIDTH-TAG_W-1:0] payload
);

    always_comb begin
        ok      = (hresp == HRESP_OKAY) && (hrdata[BUSWIDTH-1 -: TAG_W] == exp_tag);
        payload = hrdata[BUSWIDTH-TAG_W-1:0];
    end

endmodule

// File: rtl/multi_config_initializer.sv
// AHB read master that fetches five tagged configuration words per channel,
// retries bad words and publishes the per-channel image/filter settings.
module multi_config_initializer
    import init_pkg::*;
#(
    parameter int                   BUSWIDTH      = 32,
    parameter int                   TAG_W         = 3,
    parameter int                   NUM_CH        = 2,
    parameter int                   FILTER_W      = 2,
    parameter logic [BUSWIDTH-1:0]  CFG_BASE_ADDR = 32'h0000_0D00,
    parameter int                   MAX_RETRY     = 3,
    localparam int                  PAY_W         = BUSWIDTH - TAG_W
) (
    input  logic                       ahb_hclk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       ahb_hgrant,
    input  logic                       ahb_hready,
    input  logic [1:0]                 ahb_hresp,
    input  logic [BUSWIDTH-1:0]        ahb_hrdata,
    output logic                       ahb_hbusreq,
    output logic [1:0]                 ahb_htrans,
    output logic                       ahb_hwrite,
    output logic [BUSWIDTH-1:0]        ahb_haddr,
    output logic [NUM_CH*PAY_W-1:0]    width,
    output logic [NUM_CH*PAY_W-1:0]    height,
    output logic [NUM_CH*PAY_W-1:0]    readStartAddress,
    output logic [NUM_CH*PAY_W-1:0]    writeStartAddress,
    output logic [NUM_CH*FILTER_W-1:0] filterType,
    output logic                       final_enable,
    output logic                       cfg_error,
    output logic [15:0]                err_index
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RT_W = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [2:0]      LAST_WD = 3'(WORDS_PER_CH - 1);

    state_t             state, state_n;
    logic [CH_W-1:0]    ch, ch_n;
    logic [2:0]         wd, wd_n;
    logic [RT_W-1:0]    retry, retry_n;
    logic               word_ok;
    logic [PAY_W-1:0]   payload;
    logic               last_word;
    logic               accept;
    logic [BUSWIDTH-1:0] next_addr;

    init_word_checker #(
        .BUSWIDTH (BUSWIDTH),
        .TAG_W    (TAG_W)
    ) u_checker (
        .hrdata  (ahb_hrdata),
        .hresp   (ahb_hresp),
        .exp_tag (TAG_W'(wd + 3'd1)),
        .ok      (word_ok),
        .payload (payload)
    );

    always_comb begin
        state_n   = state;
        ch_n      = ch;
        wd_n      = wd;
        retry_n   = retry;
        accept    = 1'b0;
        last_word = (ch == LAST_CH) && (wd == LAST_WD);
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n = REQ;
                    ch_n    = '0;
                    wd_n    = '0;
                    retry_n = '0;
                end
            end
            REQ:  if (ahb_hgrant) state_n = ADDR;
            ADDR: if (ahb_hready) state_n = DATA;
            DATA: begin
                if (ahb_hready) begin
                    if (word_ok) begin
                        accept  = 1'b1;
                        retry_n = '0;
                        if (last_word) begin
                            state_n = DONE;
                        end else begin
                            if (wd == LAST_WD) begin
                                wd_n = '0;
                                ch_n = ch + 1'b1;
                            end else begin
                                wd_n = wd + 3'd1;
                            end
                            state_n = ahb_hgrant ? ADDR : REQ;
                        end
                    end else if (retry != RT_W'(MAX_RETRY)) begin
                        retry_n = retry + 1'b1;
                        state_n = ahb_hgrant ? ADDR : REQ;
                    end else begin
                        state_n = ERROR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        next_addr = CFG_BASE_ADDR + BUSWIDTH'(word_offset(32'(ch_n), 32'(wd_n)));
    end

    always_comb begin
        ahb_htrans  = (state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        ahb_hbusreq = (state == REQ) || (state == ADDR) || ((state == DATA) && !last_word);
        ahb_hwrite  = 1'b0;
    end

    always_ff @(posedge ahb_hclk) begin
        if (!n_rst) begin
            state             <= IDLE;
            ch                <= '0;
            wd                <= '0;
            retry             <= '0;
            ahb_haddr         <= '0;
            width             <= '0;
            height            <= '0;
            readStartAddress  <= '0;
            writeStartAddress <= '0;
            filterType        <= '0;
            final_enable      <= 1'b0;
            cfg_error         <= 1'b0;
            err_index         <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            wd    <= wd_n;
            retry <= retry_n;
            // Address is latched on entry to ADDR so it stays stable through hready stalls.
            if (state_n == ADDR) ahb_haddr <= next_addr;
            if ((state == IDLE || state == DONE || state == ERROR) && start) begin
                final_enable <= 1'b0;
                cfg_error    <= 1'b0;
            end
            if (accept) begin
                case (wd)
                    3'd0: width[int'(ch)*PAY_W +: PAY_W]             <= payload;
                    3'd1: height[int'(ch)*PAY_W +: PAY_W]            <= payload;
                    3'd2: readStartAddress[int'(ch)*PAY_W +: PAY_W]  <= payload;
                    3'd3: writeStartAddress[int'(ch)*PAY_W +: PAY_W] <= payload;
                    3'd4: filterType[int'(ch)*FILTER_W +: FILTER_W]  <= payload[FILTER_W-1:0];
                    default: ;
                endcase
            end
            if (state == DATA && state_n == DONE) final_enable <= 1'b1;
            if (state == DATA && state_n == ERROR) begin
                cfg_error <= 1'b1;
                err_index <= {13'(ch), wd};
            end
        end
    end

endmodule

// File: tb/tb_multi_config_initializer.sv
// Bench for multi_config_initializer: an AHB slave with fault injection plus a
// transaction-level model of the expected fields, status and address order.
module tb_multi_config_initializer;

    localparam int BW = 32, TW = 3, NCH = 2, FW = 2, PW = 29, MAXR = 3;
    localparam logic [31:0] BASE = 32'h0000_0D00;

    logic ahb_hclk = 1'b0;
    logic n_rst, start, ahb_hgrant, ahb_hready;
    logic [1:0] ahb_hresp;
    logic [31:0] ahb_hrdata;
    logic ahb_hbusreq, ahb_hwrite;
    logic [1:0] ahb_htrans;
    logic [31:0] ahb_haddr;
    logic [NCH*PW-1:0] width, height, readStartAddress, writeStartAddress;
    logic [NCH*FW-1:0] filterType;
    logic final_enable, cfg_error;
    logic [15:0] err_index;

    always #5 ahb_hclk = ~ahb_hclk;

    multi_config_initializer #(
        .BUSWIDTH(BW), .TAG_W(TW), .NUM_CH(NCH), .FILTER_W(FW),
        .CFG_BASE_ADDR(BASE), .MAX_RETRY(MAXR)
    ) dut (
        .ahb_hclk(ahb_hclk), .n_rst(n_rst), .start(start),
        .ahb_hgrant(ahb_hgrant), .ahb_hready(ahb_hready), .ahb_hresp(ahb_hresp),
        .ahb_hrdata(ahb_hrdata), .ahb_hbusreq(ahb_hbusreq), .ahb_htrans(ahb_htrans),
        .ahb_hwrite(ahb_hwrite), .ahb_haddr(ahb_haddr), .width(width), .height(height),
        .readStartAddress(readStartAddress), .writeStartAddress(writeStartAddress),
        .filterType(filterType), .final_enable(final_enable), .cfg_error(cfg_error),
        .err_index(err_index)
    );

    int n_checks = 0, n_errors = 0;

    // slave memory, fault plan (kind 0 = wrong tag, 1 = hresp 01, 2 = random non-OKAY)
    logic [31:0] mem [10];
    int fault_left [10];
    int fault_kind [10];
    int reads [10];
    logic [31:0] addr_log [$];

    // expected configuration, indexed [channel][word]
    logic [PW-1:0] m_f [NCH][5];
    bit m_busy, m_done, m_err;
    logic [15:0] m_eidx;
    int m_c, m_k, m_retry, m_words;

    bit dphase;
    int dword;
    int p_grant = 100, p_ready = 100;
    int stall_word = -1, a_stall = 0, d_stall = 0;
    int drop_after = -1, drop_left = 0;

    logic pv_nrst, pv_start, pv_grant, pv_ready;
    logic [1:0] pv_resp, pv_htrans;
    logic [31:0] pv_rdata, pv_haddr;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_pay(int k);
        logic [63:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c*PW +: PW] = m_f[c][k];
        return v;
    endfunction

    function automatic logic [63:0] exp_filt();
        logic [63:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c*FW +: FW] = m_f[c][4][FW-1:0];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 5; k++) m_f[c][k] = '0;
        m_busy = 0; m_done = 0; m_err = 0; m_eidx = '0;
        m_c = 0; m_k = 0; m_retry = 0; m_words = 0;
        dphase = 0;
    endtask

    task automatic deliver(logic [31:0] rd, logic [1:0] rs);
        bit ok;
        if (fault_left[dword] > 0) fault_left[dword]--;
        if (!m_busy) return;
        ok = (rs == 2'b00) && (rd[31:29] == 3'(m_k + 1));
        if (ok) begin
            m_f[m_c][m_k] = rd[PW-1:0];
            m_retry = 0;
            m_words++;
            if (m_c == NCH - 1 && m_k == 4) begin
                m_busy = 0; m_done = 1;
            end else if (m_k == 4) begin
                m_k = 0; m_c++;
            end else begin
                m_k++;
            end
        end else if (m_retry < MAXR) begin
            m_retry++;
        end else begin
            m_busy = 0; m_err = 1;
            m_eidx = {13'(m_c), 3'(m_k)};
        end
    endtask

    task automatic compare();
        chk("width", width, exp_pay(0));
        chk("height", height, exp_pay(1));
        chk("readStartAddress", readStartAddress, exp_pay(2));
        chk("writeStartAddress", writeStartAddress, exp_pay(3));
        chk("filterType", filterType, exp_filt());
        chk("final_enable", final_enable, m_done);
        chk("cfg_error", cfg_error, m_err);
        if (m_err) chk("err_index", err_index, m_eidx);
        chk("hwrite", ahb_hwrite, 0);
        if (!m_busy) begin
            chk("htrans_when_idle", ahb_htrans, 0);
            chk("hbusreq_when_idle", ahb_hbusreq, 0);
        end
        if (ahb_htrans == 2'b10) begin
            if (pv_nrst) chk("nonseq_needs_grant", pv_grant || (pv_htrans == 2'b10 && !pv_ready), 1);
            if (pv_nrst && pv_htrans == 2'b10 && !pv_ready) chk("haddr_stable", ahb_haddr, pv_haddr);
        end else begin
            chk("htrans_legal", ahb_htrans, 0);
        end
    endtask

    task automatic drive();
        logic r;
        ahb_hgrant = ($urandom_range(99) < p_grant);
        if (drop_left > 0 && drop_after >= 0 && m_words >= drop_after) begin
            ahb_hgrant = 1'b0; drop_left--;
        end
        r = ($urandom_range(99) < p_ready);
        if (ahb_htrans == 2'b10 && stall_word >= 0 && ahb_haddr == BASE + 32'(4*stall_word) && a_stall > 0) begin
            r = 1'b0; a_stall--;
        end
        if (dphase && dword == stall_word && d_stall > 0) begin
            r = 1'b0; d_stall--;
        end
        ahb_hready = r;
        if (dphase && fault_left[dword] > 0) begin
            case (fault_kind[dword])
                0:       begin ahb_hrdata = {3'(((dword % 5) + 2) % 8), mem[dword][PW-1:0]}; ahb_hresp = 2'b00; end
                1:       begin ahb_hrdata = mem[dword]; ahb_hresp = 2'b01; end
                default: begin ahb_hrdata = mem[dword]; ahb_hresp = 2'(1 + $urandom_range(2)); end
            endcase
        end else if (dphase) begin
            ahb_hrdata = mem[dword]; ahb_hresp = 2'b00;
        end else begin
            ahb_hrdata = $urandom; ahb_hresp = 2'b00;
        end
    endtask

    task automatic tick();
        bit was_busy;
        pv_nrst = n_rst; pv_start = start; pv_grant = ahb_hgrant; pv_ready = ahb_hready;
        pv_resp = ahb_hresp; pv_rdata = ahb_hrdata; pv_htrans = ahb_htrans; pv_haddr = ahb_haddr;
        @(negedge ahb_hclk);
        if (!pv_nrst) begin
            model_reset();
        end else begin
            was_busy = m_busy;
            if (dphase && pv_ready) begin
                dphase = 0;
                deliver(pv_rdata, pv_resp);
            end
            if (pv_htrans == 2'b10 && pv_ready) begin
                chk("addr_order", pv_haddr, BASE + 32'(4*(5*m_c + m_k)));
                addr_log.push_back(pv_haddr);
                dword = int'((pv_haddr - BASE) >> 2);
                if (dword < 0 || dword > 9) dword = 0;
                reads[dword]++;
                dphase = 1;
            end
            if (pv_start && !was_busy) begin
                m_busy = 1; m_done = 0; m_err = 0;
                m_c = 0; m_k = 0; m_retry = 0; m_words = 0;
            end
        end
        compare();
        drive();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic run_until_idle(int budget);
        int n = 0;
        while (m_busy && n < budget) begin tick(); n++; end
        chk("load_within_budget", n < budget, 1);
    endtask

    task automatic load_default_mem();
        logic [31:0] d [10] = '{32'h20000151, 32'h40000151, 32'h600001F4, 32'h8000157C, 32'hA0000001,
                               32'h200000A0, 32'h40000078, 32'h60001000, 32'h80002000, 32'hA0000002};
        for (int i = 0; i < 10; i++) begin
            mem[i] = d[i]; fault_left[i] = 0; fault_kind[i] = 0; reads[i] = 0;
        end
    endtask

    // Cycles from the first NONSEQ address phase to final_enable.
    task automatic timed_load(output int lat);
        int n = 0;
        addr_log.delete();
        pulse_start();
        while (ahb_htrans != 2'b10 && n < 20) begin tick(); n++; end
        lat = 0;
        while (!final_enable && lat < 200) begin tick(); lat++; end
    endtask

    initial begin
        int lat, n;
        n_rst = 1'b0; start = 1'b0;
        load_default_mem();
        model_reset();
        drive();
        tick(); tick();
        chk("reset_haddr", ahb_haddr, 0);
        chk("reset_htrans", ahb_htrans, 0);
        chk("reset_final", final_enable, 0);
        n_rst = 1'b1;
        tick();

        // clean load with grant and ready held high
        timed_load(lat);
        chk("latency_clean", lat, 20);
        chk("width0_literal", width[PW-1:0], 29'h151);
        chk("filter1_literal", filterType[2*FW-1:FW], 2);
        chk("addr_count", addr_log.size(), 10);
        for (int i = 0; i < 10 && i < addr_log.size(); i++)
            chk("haddr_sequence", addr_log[i], BASE + 32'(4*i));

        // word 2 stalled 3 cycles in both address and data phase
        stall_word = 2; a_stall = 3; d_stall = 3;
        timed_load(lat);
        chk("latency_stalled", lat, 26);
        chk("width0_after_stall", width[PW-1:0], 29'h151);
        stall_word = -1;

        // word 1 returns tag 011 twice, third read is good
        for (int i = 0; i < 10; i++) reads[i] = 0;
        fault_left[1] = 2; fault_kind[1] = 0;
        pulse_start();
        run_until_idle(200);
        chk("retry_reads_D04", reads[1], 3);
        chk("height0_literal", height[PW-1:0], 29'h151);
        chk("retry_no_error", cfg_error, 0);
        chk("retry_final", final_enable, 1);

        // ch1 word 3 fails MAX_RETRY+1 times
        for (int i = 0; i < 10; i++) reads[i] = 0;
        fault_left[8] = 4; fault_kind[8] = 1;
        pulse_start();
        run_until_idle(200);
        chk("err_flag", cfg_error, 1);
        chk("err_index_literal", err_index, 16'h000B);
        chk("err_final_low", final_enable, 0);
        chk("err_reads_D20", reads[8], 4);
        chk("err_ch0_width", width[PW-1:0], 29'h151);
        chk("err_ch0_filter", filterType[FW-1:0], 1);

        // reset during the data phase of word 7
        pulse_start();
        n = 0;
        while (!(dphase && dword == 7) && n < 200) begin tick(); n++; end
        chk("reach_word7", n < 200, 1);
        n_rst = 1'b0; tick(); n_rst = 1'b1;
        chk("rst_htrans", ahb_htrans, 0);
        chk("rst_haddr", ahb_haddr, 0);
        chk("rst_hbusreq", ahb_hbusreq, 0);
        chk("rst_width", width, 0);
        chk("rst_filter", filterType, 0);
        chk("rst_err_index", err_index, 0);
        pulse_start();
        run_until_idle(200);
        chk("reload_final", final_enable, 1);
        chk("reload_filter", filterType, 4'h9);

        // grant withdrawn after five words
        drop_after = 5; drop_left = 6;
        pulse_start();
        n = 0;
        while (m_busy && n < 300) begin
            tick(); n++;
            if (m_busy && !ahb_hgrant) chk("hbusreq_held", ahb_hbusreq, 1);
        end
        chk("drop_done", final_enable, 1);
        drop_after = -1;

        // randomized loads: random data, bus timing, faults and stray starts
        for (int r = 0; r < 8; r++) begin
            p_grant = $urandom_range(100, 50);
            p_ready = $urandom_range(100, 50);
            for (int i = 0; i < 10; i++) begin
                mem[i] = {3'((i % 5) + 1), 29'($urandom)};
                fault_left[i] = ($urandom_range(7) == 0) ? $urandom_range(4, 1) : 0;
                fault_kind[i] = $urandom_range(2);
            end
            pulse_start();
            n = 0;
            while (m_busy && n < 3000) begin
                start = ($urandom_range(39) == 0);
                tick(); n++;
            end
            start = 1'b0;
            chk("random_load_budget", n < 3000, 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
